// File: rtl/cache_ctrl_fsm_if.sv
// Request/response and RAM-side bus of the 2-way write-back cache controller.
//   master: requester plus RAM macro (drives req_*, ram_rdata)
//   slave : cache controller (drives req_ready, resp_*, ram_addr/wdata/wren)
interface cache_ctrl_fsm_if #(
    parameter int unsigned INDEX_W = 3,
    parameter int unsigned TAG_W   = 2,
    parameter int unsigned DATA_W  = 8
);
    localparam int unsigned ADDR_W = TAG_W + INDEX_W;

    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_hit;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, ram_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_hit,
        input  ram_addr, ram_wdata, ram_wren
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, ram_rdata,
        output req_ready, resp_valid, resp_rdata, resp_hit,
        output ram_addr, ram_wdata, ram_wren
    );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// Sequencing controller for a 2-way set-associative write-back data cache
// (8 sets x 2 ways, entries {V, D, LRU, tag, data}) in front of a 32x8
// synchronous RAM with 1-cycle read latency.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : req_valid/req_write/req_addr/req_wdata/req_ready,
//                  resp_valid/resp_rdata/resp_hit,
//                  ram_addr/ram_wdata/ram_wren/ram_rdata
// All bus outputs are registered.
module cache_ctrl_fsm #(
    parameter int unsigned INDEX_W = 3,
    parameter int unsigned TAG_W   = 2,
    parameter int unsigned DATA_W  = 8
) (
    input  logic           clock,
    input  logic           reset,
    cache_ctrl_fsm_if.slave bus
);
    localparam int unsigned ADDR_W = TAG_W + INDEX_W;
    localparam int unsigned SETS   = 1 << INDEX_W;

    typedef struct packed {
        logic              v;
        logic              d;
        logic              lru;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WRITEBACK, FILL, FILL_WAIT, RESP
    } state_t;

    state_t state_q, state_d;

    entry_t [SETS-1:0][1:0] cache_q;

    // Captured request and chosen victim
    logic               req_write_q;
    logic [TAG_W-1:0]   req_tag_q;
    logic [INDEX_W-1:0] req_idx_q;
    logic [DATA_W-1:0]  req_wdata_q;
    logic               victim_q, victim_d;

    // Output registers
    logic              req_ready_q,  req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_hit_q,   resp_hit_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              ram_wren_q,   ram_wren_d;
    logic [ADDR_W-1:0] ram_addr_q,   ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q,  ram_wdata_d;

    // Storage update controls
    logic   cap_en;
    logic   wr_en;
    logic   wr_way;
    logic   wb_en;
    entry_t wr_entry;

    // Lookup of the captured set
    entry_t way0, way1, hit_e;
    logic   hit0, hit1, hit_any, hit_way, victim_sel, victim_dirty;
    logic [TAG_W-1:0]  victim_tag;
    logic [DATA_W-1:0] victim_data;

    assign way0    = cache_q[req_idx_q][0];
    assign way1    = cache_q[req_idx_q][1];
    assign hit0    = way0.v && (way0.tag == req_tag_q);
    assign hit1    = way1.v && (way1.tag == req_tag_q);
    assign hit_any = hit0 || hit1;
    assign hit_way = !hit0;
    assign hit_e   = hit_way ? way1 : way0;

    // Victim: invalid way 0, invalid way 1, least-recently-used way, else way 0
    always_comb begin
        victim_sel = 1'b0;
        if (!way0.v)       victim_sel = 1'b0;
        else if (!way1.v)  victim_sel = 1'b1;
        else if (way0.lru) victim_sel = 1'b0;
        else if (way1.lru) victim_sel = 1'b1;
    end

    assign victim_dirty = victim_sel ? (way1.v && way1.d) : (way0.v && way0.d);
    assign victim_tag   = victim_sel ? way1.tag  : way0.tag;
    assign victim_data  = victim_sel ? way1.data : way0.data;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state, storage controls and next values of registered outputs
    always_comb begin
        state_d      = state_q;
        cap_en       = 1'b0;
        victim_d     = victim_q;
        wr_en        = 1'b0;
        wr_way       = 1'b0;
        wr_entry     = '0;
        wb_en        = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_hit_d   = resp_hit_q;
        ram_wren_d   = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    cap_en  = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit_any) begin
                    wr_en        = 1'b1;
                    wr_way       = hit_way;
                    wr_entry     = hit_e;
                    wr_entry.lru = 1'b0;
                    if (req_write_q) begin
                        wr_entry.data = req_wdata_q;
                        wr_entry.d    = 1'b1;
                    end
                    resp_rdata_d = req_write_q ? req_wdata_q : hit_e.data;
                    resp_hit_d   = 1'b1;
                    state_d      = RESP;
                end else begin
                    victim_d = victim_sel;
                    if (victim_dirty) begin
                        ram_wren_d  = 1'b1;
                        ram_addr_d  = {victim_tag, req_idx_q};
                        ram_wdata_d = victim_data;
                        state_d     = WRITEBACK;
                    end else begin
                        ram_addr_d = {req_tag_q, req_idx_q};
                        state_d    = FILL;
                    end
                end
            end
            WRITEBACK: begin
                wb_en      = 1'b1;
                ram_addr_d = {req_tag_q, req_idx_q};
                state_d    = FILL;
            end
            FILL: begin
                // RAM samples the fill address at the end of this cycle
                state_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                wr_en         = 1'b1;
                wr_way        = victim_q;
                wr_entry.v    = 1'b1;
                wr_entry.d    = req_write_q;
                wr_entry.lru  = 1'b0;
                wr_entry.tag  = req_tag_q;
                wr_entry.data = req_write_q ? req_wdata_q : bus.ram_rdata;
                resp_rdata_d  = wr_entry.data;
                resp_hit_d    = 1'b0;
                state_d       = RESP;
            end
            RESP: begin
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    // Request capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_write_q <= 1'b0;
            req_tag_q   <= '0;
            req_idx_q   <= '0;
            req_wdata_q <= '0;
            victim_q    <= 1'b0;
        end else begin
            victim_q <= victim_d;
            if (cap_en) begin
                req_write_q <= bus.req_write;
                req_tag_q   <= bus.req_addr[ADDR_W-1:INDEX_W];
                req_idx_q   <= bus.req_addr[INDEX_W-1:0];
                req_wdata_q <= bus.req_wdata;
            end
        end
    end

    // Tag/data storage; touching a way makes its partner the LRU way
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cache_q <= '0;
        end else begin
            if (wb_en) cache_q[req_idx_q][victim_q].d <= 1'b0;
            if (wr_en) begin
                cache_q[req_idx_q][wr_way]      <= wr_entry;
                cache_q[req_idx_q][~wr_way].lru <= 1'b1;
            end
        end
    end

    // Output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_hit_q   <= 1'b0;
            ram_wren_q   <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_hit_q   <= resp_hit_d;
            ram_wren_q   <= ram_wren_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_hit   = resp_hit_q;
    assign bus.ram_wren   = ram_wren_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Bench for cache_ctrl_fsm: RAM behavioural model, cache reference model
// kept as plain per-set arrays with a most-recently-used way, directed
// scenarios followed by randomized traffic and a reset abort.
module tb_cache_ctrl_fsm;
    logic clock;
    logic reset;

    cache_ctrl_fsm_if bus ();

    cache_ctrl_fsm dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // RAM macro: synchronous, 1-cycle read latency, preload port for the bench
    logic [7:0] mem [32];
    logic       ram_load;
    logic [4:0] load_addr;
    logic [7:0] load_data;

    always @(posedge clock) begin
        if (ram_load)          mem[load_addr]    <= load_data;
        else if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    // Reference model
    logic       m_v    [8][2];
    logic       m_d    [8][2];
    logic [1:0] m_tag  [8][2];
    logic [7:0] m_data [8][2];
    int         m_last [8];
    logic [7:0] ref_mem [32];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 2; w++) begin
                m_v[s][w]    = 1'b0;
                m_d[s][w]    = 1'b0;
                m_tag[s][w]  = 2'b0;
                m_data[s][w] = 8'h0;
            end
            m_last[s] = 0;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({pfx, "_resp_rdata"}, 32'(bus.resp_rdata), 32'd0);
        check({pfx, "_resp_hit"},   32'(bus.resp_hit),   32'd0);
        check({pfx, "_ram_wren"},   32'(bus.ram_wren),   32'd0);
        check({pfx, "_ram_addr"},   32'(bus.ram_addr),   32'd0);
        check({pfx, "_ram_wdata"},  32'(bus.ram_wdata),  32'd0);
        check({pfx, "_req_ready"},  32'(bus.req_ready),  32'd1);
    endtask

    // Issue one request in the current (ready) cycle and check its outcome.
    // flood keeps req_valid high with junk requests while this one is busy.
    task automatic do_req(input logic wr, input logic [4:0] addr, input logic [7:0] wd,
                          input bit flood);
        logic [2:0] idx;
        logic [1:0] tg;
        int         hw, vw, lat;
        logic       exp_hit;
        logic [7:0] exp_rd, wb_data;
        logic [4:0] wb_addr;
        bit         exp_wb;
        int         got_lat, wb_cnt, early_ready;
        logic       got_hit, got_ready;
        logic [7:0] got_rd, got_wb_data;
        logic [4:0] got_wb_addr, got_fill;
        string      nm;

        idx = addr[2:0];
        tg  = addr[4:3];
        hw  = -1;
        for (int w = 0; w < 2; w++)
            if (hw < 0 && m_v[idx][w] && m_tag[idx][w] == tg) hw = w;
        exp_wb  = 1'b0;
        wb_addr = 5'h0;
        wb_data = 8'h0;
        if (hw >= 0) begin
            exp_hit = 1'b1;
            lat     = 2;
            if (wr) begin
                m_data[idx][hw] = wd;
                m_d[idx][hw]    = 1'b1;
            end
            exp_rd      = m_data[idx][hw];
            m_last[idx] = hw;
        end else begin
            exp_hit = 1'b0;
            if (!m_v[idx][0])      vw = 0;
            else if (!m_v[idx][1]) vw = 1;
            else                   vw = 1 - m_last[idx];
            if (m_v[idx][vw] && m_d[idx][vw]) begin
                exp_wb           = 1'b1;
                wb_addr          = {m_tag[idx][vw], idx};
                wb_data          = m_data[idx][vw];
                ref_mem[wb_addr] = wb_data;
            end
            lat             = exp_wb ? 5 : 4;
            exp_rd          = wr ? wd : ref_mem[addr];
            m_v[idx][vw]    = 1'b1;
            m_d[idx][vw]    = wr;
            m_tag[idx][vw]  = tg;
            m_data[idx][vw] = exp_rd;
            m_last[idx]     = vw;
        end

        nm = $sformatf("%s%02h", wr ? "wr" : "rd", addr);
        check({nm, "_ready_at_issue"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(posedge clock);
        #1;
        if (flood) begin
            bus.req_write = 1'($urandom);
            bus.req_addr  = 5'($urandom);
            bus.req_wdata = 8'($urandom);
        end else begin
            bus.req_valid = 1'b0;
        end

        got_lat = 0; wb_cnt = 0; early_ready = 0;
        got_hit = 1'b0; got_ready = 1'b0; got_rd = 8'h0;
        got_wb_addr = 5'h0; got_wb_data = 8'h0; got_fill = 5'h0;
        for (int c = 1; c <= 12 && got_lat == 0; c++) begin
            @(posedge clock);
            #1;
            if (bus.ram_wren) begin
                wb_cnt++;
                got_wb_addr = bus.ram_addr;
                got_wb_data = bus.ram_wdata;
            end
            if (c == lat - 3) got_fill = bus.ram_addr;
            if (bus.resp_valid) begin
                got_lat   = c;
                got_rd    = bus.resp_rdata;
                got_hit   = bus.resp_hit;
                got_ready = bus.req_ready;
            end else begin
                if (bus.req_ready) early_ready++;
                if (flood) begin
                    bus.req_write = 1'($urandom);
                    bus.req_addr  = 5'($urandom);
                    bus.req_wdata = 8'($urandom);
                end
            end
        end

        check({nm, "_latency"},     32'(got_lat),     32'(lat));
        check({nm, "_rdata"},       32'(got_rd),      32'(exp_rd));
        check({nm, "_hit"},         32'(got_hit),     32'(exp_hit));
        check({nm, "_busy_ready"},  32'(early_ready), 32'd0);
        check({nm, "_resp_ready"},  32'(got_ready),   32'd1);
        check({nm, "_wren_cycles"}, 32'(wb_cnt),      32'(exp_wb));
        if (exp_wb) begin
            check({nm, "_wb_addr"}, 32'(got_wb_addr), 32'(wb_addr));
            check({nm, "_wb_data"}, 32'(got_wb_data), 32'(wb_data));
        end
        if (!exp_hit) check({nm, "_fill_addr"}, 32'(got_fill), 32'(addr));
    endtask

    initial begin
        int wren_seen, rv_seen;
        logic [7:0] v;

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 5'h0;
        bus.req_wdata = 8'h0;
        ram_load      = 1'b0;
        load_addr     = 5'h0;
        load_data     = 8'h0;
        model_clear();

        // Preload RAM while the controller is held in reset
        for (int a = 0; a < 32; a++) begin
            @(negedge clock);
            v = 8'($urandom);
            if (a == 5)    v = 8'hA5;
            if (a == 'h12) v = 8'h77;
            ram_load   = 1'b1;
            load_addr  = 5'(a);
            load_data  = v;
            ref_mem[a] = v;
        end
        @(negedge clock);
        ram_load = 1'b0;
        check_reset_outputs("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Clean miss then hit
        do_req(1'b0, 5'h05, 8'h00, 1'b0);
        do_req(1'b0, 5'h05, 8'h00, 1'b0);
        // Write miss installs dirty, then read hit
        do_req(1'b1, 5'h0D, 8'h3C, 1'b0);
        do_req(1'b0, 5'h0D, 8'h00, 1'b0);
        // LRU in set 5
        do_req(1'b0, 5'h05, 8'h00, 1'b0);
        do_req(1'b0, 5'h0D, 8'h00, 1'b0);
        do_req(1'b0, 5'h05, 8'h00, 1'b0);
        do_req(1'b0, 5'h15, 8'h00, 1'b0);
        do_req(1'b0, 5'h05, 8'h00, 1'b0);
        do_req(1'b0, 5'h0D, 8'h00, 1'b0);
        // Dirty eviction in set 2
        do_req(1'b1, 5'h02, 8'h11, 1'b0);
        do_req(1'b1, 5'h0A, 8'h22, 1'b0);
        do_req(1'b0, 5'h12, 8'h00, 1'b0);
        // req_valid held high across busy periods
        do_req(1'b0, 5'h1D, 8'h00, 1'b1);
        do_req(1'b1, 5'h0A, 8'h99, 1'b1);
        do_req(1'b0, 5'h02, 8'h00, 1'b1);
        bus.req_valid = 1'b0;

        // Randomized traffic on sets 1, 3, 6
        for (int n = 0; n < 60; n++) begin
            logic [2:0] s;
            logic [4:0] a;
            case ($urandom_range(0, 2))
                0:       s = 3'd1;
                1:       s = 3'd3;
                default: s = 3'd6;
            endcase
            a = {2'($urandom), s};
            do_req(1'($urandom), a, 8'($urandom), ($urandom_range(0, 3) == 0));
        end
        bus.req_valid = 1'b0;

        // Reset during FILL_WAIT of a dirty miss in set 7
        do_req(1'b1, 5'h07, 8'h5A, 1'b0);
        do_req(1'b1, 5'h0F, 8'h6B, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 5'h17;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        wren_seen = 0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clock);
            #1;
            if (bus.ram_wren) wren_seen++;
        end
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        check("midrst_wb_before_abort", 32'(wren_seen), 32'd1);
        ref_mem[5'h07] = 8'h5A;
        wren_seen = 0;
        rv_seen   = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            if (bus.ram_wren)   wren_seen++;
            if (bus.resp_valid) rv_seen++;
        end
        check("midrst_no_wren", 32'(wren_seen), 32'd0);
        check("midrst_no_resp", 32'(rv_seen),   32'd0);
        reset = 1'b0;
        model_clear();
        @(posedge clock);
        #1;
        check("post_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        do_req(1'b0, 5'h17, 8'h00, 1'b0);
        do_req(1'b0, 5'h07, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cache_ctrl_fsm.md
# cache_ctrl_fsm

Sequencing controller for the 2-way set-associative, write-back data cache in front of the 32×8 RAM. It accepts one read or write request at a time and performs the tag lookup across both ways. On a miss it chooses a victim by LRU, writes the victim back if dirty, fills the line from RAM, and returns a single-cycle response. Tag/data storage is held internally: 8 sets × 2 ways of 13-bit entries {V, D, LRU, tag[1:0], data[7:0]}. The RAM macro (synchronous, 1-cycle read latency) is driven through the `ram_*` port.

## Interface
- INDEX_W, 3, set-index width (8 sets)
- TAG_W, 2, tag width; RAM address width = TAG_W+INDEX_W = 5
- DATA_W, 8, data word width
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present; sampled only when req_ready=1
- req_write  in  1  1=write, 0=read
- req_addr  in  5  {tag[4:3], index[2:0]}
- req_wdata  in  8  write data
- req_ready  out  1  high only in IDLE
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  8  read data (write: the written value)
- resp_hit  out  1  1=request hit in cache
- ram_addr  out  5  RAM address
- ram_wdata  out  8  RAM write data
- ram_wren  out  1  RAM write enable, one cycle per write-back
- ram_rdata  in  8  RAM read data, valid the cycle after address presented with ram_wren=0

## Operation
- States: IDLE, LOOKUP, WRITEBACK, FILL, FILL_WAIT, RESP.
- IDLE: req_ready=1. When req_valid=1, capture write/addr/wdata and go to LOOKUP.
- LOOKUP (1 cycle): way w hits if V[w]=1 and tag[w]=captured tag. Way 0 has priority if both match; that condition is illegal and must not arise.
  - Hit, read: latch data → RESP, hit=1.
  - Hit, write: data[w]←wdata, D[w]←1 → RESP, hit=1.
  - Miss: select victim. Invalid way 0 first, else invalid way 1, else the way with LRU=1, else way 0. If the victim has V=1 and D=1 → WRITEBACK, otherwise → FILL.
- WRITEBACK (1 cycle): ram_addr={victim tag, index}, ram_wdata=victim data, ram_wren=1; D[victim]←0 → FILL.
- FILL (1 cycle): ram_addr={req tag, index}, ram_wren=0 → FILL_WAIT.
- FILL_WAIT (1 cycle): install the victim way with V←1 and tag←req tag.
  - Read: data←ram_rdata, D←0.
  - Write: data←wdata, D←1. The RAM value is discarded.
  - Response hit=0 → RESP.
- LRU update on every hit or install to way w: LRU[w]←0, LRU[other]←1.
- RESP: resp_valid=1, resp_rdata and resp_hit held stable → IDLE.
- Requests are never queued. req_valid outside IDLE is ignored.
- The cache never writes RAM except in WRITEBACK. There is no write-through and no flush.

## Timing
- Reset (asynchronous): state=IDLE and all 16 entries cleared to 13'b0. Outputs: resp_valid=0, resp_rdata=0, resp_hit=0, ram_wren=0, ram_addr=0, ram_wdata=0, req_ready=1.
- Latency, counted from the accepting edge to the first cycle with resp_valid=1:
  - hit: 2 cycles
  - clean miss: 4 cycles
  - dirty miss: 5 cycles
- Maximum throughput on hits is one request per 3 cycles, since IDLE is re-entered after RESP.
- All outputs are registered. ram_wren is high for exactly one cycle per write-back.
- Reset mid-operation aborts immediately. No further RAM write is issued, and dirty lines are lost by design.
- Write-back and refill of the same RAM address cannot occur for one miss, because tags differ.

## Test plan
- Reset, then read 0x05 with RAM[5]=0xA5. Expect a miss: ram_wren stays 0 and ram_addr=5. Then resp_valid, resp_rdata=0xA5, resp_hit=0 arrive 4 cycles after accept. Re-reading 0x05 must hit with 0xA5 after 2 cycles.
- Write 0x0D←0x3C on an empty cache. Expect a miss install with D=1, resp_rdata=0x3C, and no ram_wren. A subsequent read of 0x0D must hit with 0x3C.
- Set 5 LRU: read 0x05 (way 0), read 0x0D (way 1), read 0x05 again, then read 0x15. The victim must be way 1 (tag 1), so a later read of 0x0D misses and a read of 0x05 hits.
- Dirty eviction: write 0x02←0x11, write 0x0A←0x22, then read 0x12 with RAM[0x12]=0x77. Expect a WRITEBACK of ram_addr=0x02, ram_wdata=0x11, ram_wren=1 for one cycle, then resp_rdata=0x77 at latency 5.
- Assert req_valid continuously with a new address during a miss. Only one request is accepted, and the next acceptance occurs only in the cycle after RESP.
- Assert reset during FILL_WAIT of a dirty miss. All outputs immediately take their reset values, no resp_valid is produced, and a read of the same address then misses.
